// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall-bus, stage index and sequencer state definitions
package pipe_ctrl_pkg;

    localparam int STALL_W = 5;
    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;

    localparam stall_bus_t STALL_NONE    = 5'b00000;
    localparam stall_bus_t STALL_PC_HOLD = 5'b00001;

    typedef enum logic [1:0] {
        CTRL_HALTED = 2'd0,
        CTRL_RUN    = 2'd1,
        CTRL_STEP   = 2'd2,
        CTRL_DRAIN  = 2'd3
    } ctrl_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] bits);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + {2'b00, bits[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/pipe_occupancy.sv
// rtl/pipe_occupancy.sv - valid-bit tracking of the IF_ID..MEM_WB slots from the stall vector
module pipe_occupancy
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  stall_bus_t stall_i,
    output logic [4:1] v_o,
    output logic [2:0] inflight_o,
    output logic       retire_o
);

    logic [4:1] v_q;
    logic [4:1] v_d;

    // A held stage keeps its slot; a held producer feeding a moving stage leaves a bubble.
    always_comb begin
        v_d = v_q;
        if (stall_i[STALL_IFID]) begin
            v_d[1] = v_q[1];
        end else begin
            v_d[1] = ~stall_i[STALL_PC];
        end
        for (int k = 2; k <= 4; k++) begin
            if (stall_i[k]) begin
                v_d[k] = v_q[k];
            end else if (stall_i[k-1]) begin
                v_d[k] = 1'b0;
            end else begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 4'b0000;
        end else begin
            v_q <= v_d;
        end
    end

    assign v_o        = v_q;
    assign inflight_o = rst ? 3'd0 : popcount4(v_q);
    assign retire_o   = rst ? 1'b0 : v_q[4];

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - run/halt/step sequencer producing the per-stage stall vector
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             halt_i,
    input  logic             step_i,
    input  logic             stallreq_id_i,
    output logic [4:0]       stall_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic [2:0]       inflight_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    stall_bus_t       stall;
    logic [4:1]       v;

    always_comb begin
        stall = STALL_PC_HOLD;
        if (!rst) begin
            unique case (state_q)
                CTRL_HALTED: stall = STALL_PC_HOLD;
                CTRL_RUN,
                CTRL_STEP:   stall = {3'b000, stallreq_id_i, stallreq_id_i};
                CTRL_DRAIN:  stall = {3'b000, stallreq_id_i, 1'b1};
                default:     stall = STALL_PC_HOLD;
            endcase
        end
    end

    // STEP leaves on the cycle its single fetch actually happens.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CTRL_HALTED: begin
                if (halt_i) begin
                    state_d = CTRL_HALTED;
                end else if (run_i) begin
                    state_d = CTRL_RUN;
                end else if (step_i) begin
                    state_d = CTRL_STEP;
                end
            end
            CTRL_RUN: begin
                if (halt_i) begin
                    state_d = CTRL_DRAIN;
                end
            end
            CTRL_STEP: begin
                if (!stallreq_id_i) begin
                    state_d = CTRL_DRAIN;
                end
            end
            CTRL_DRAIN: begin
                if (v == 4'b0000) begin
                    state_d = CTRL_HALTED;
                end
            end
            default: state_d = CTRL_HALTED;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (v[4]) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTRL_HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pipe_occupancy u_occupancy (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .v_o        (v),
        .inflight_o (inflight_o),
        .retire_o   (retire_o)
    );

    assign stall_o      = stall;
    assign state_o      = rst ? 2'd0 : state_q;
    assign halted_o     = rst || (state_q == CTRL_HALTED);
    assign retire_cnt_o = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed checks of pipe_ctrl against a slot-level pipeline model
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int ST_HALTED = 0;
    localparam int ST_RUN    = 1;
    localparam int ST_STEP   = 2;
    localparam int ST_DRAIN  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run_i = 1'b0;
    logic             halt_i = 1'b0;
    logic             step_i = 1'b0;
    logic             stallreq_id_i = 1'b0;
    logic [4:0]       stall_o;
    logic [1:0]       state_o;
    logic             halted_o;
    logic [2:0]       inflight_o;
    logic             retire_o;
    logic [CNT_W-1:0] retire_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int retire_seen = 0;

    int m_state = ST_HALTED;
    int m_slot [1:4];
    int m_tag = 0;
    int m_cnt = 0;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run_i),
        .halt_i        (halt_i),
        .step_i        (step_i),
        .stallreq_id_i (stallreq_id_i),
        .stall_o       (stall_o),
        .state_o       (state_o),
        .halted_o      (halted_o),
        .inflight_o    (inflight_o),
        .retire_o      (retire_o),
        .retire_cnt_o  (retire_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: each slot holds an instruction tag (0 = bubble); stages move per the hold vector.
    task automatic model_cycle(input logic r, input logic h, input logic s, input logic sq, input logic rs);
        logic [4:0] held;
        int nxt [1:4];
        int occ;
        bit empty;
        if (rs) begin
            check("stall_rst", 32'(stall_o), 32'd1);
            check("state_rst", 32'(state_o), 32'd0);
            check("halted_rst", 32'(halted_o), 32'd1);
            check("inflight_rst", 32'(inflight_o), 32'd0);
            check("retire_rst", 32'(retire_o), 32'd0);
            check("cnt_rst", 32'(retire_cnt_o), 32'd0);
            m_state = ST_HALTED;
            for (int k = 1; k <= 4; k++) m_slot[k] = 0;
            m_cnt = 0;
            return;
        end
        case (m_state)
            ST_HALTED: held = 5'b00001;
            ST_DRAIN:  held = {3'b000, sq, 1'b1};
            default:   held = {3'b000, sq, sq};
        endcase
        occ = 0;
        for (int k = 1; k <= 4; k++) if (m_slot[k] != 0) occ++;
        check("stall", 32'(stall_o), 32'(held));
        check("state", 32'(state_o), 32'(m_state));
        check("halted", 32'(halted_o), (m_state == ST_HALTED) ? 32'd1 : 32'd0);
        check("inflight", 32'(inflight_o), 32'(occ));
        check("retire", 32'(retire_o), (m_slot[4] != 0) ? 32'd1 : 32'd0);
        check("cnt", 32'(retire_cnt_o), 32'(m_cnt));
        for (int k = 1; k <= 4; k++) begin
            if (held[k]) nxt[k] = m_slot[k];
            else if (held[k-1]) nxt[k] = 0;
            else if (k == 1) begin m_tag++; nxt[k] = m_tag; end
            else nxt[k] = m_slot[k-1];
        end
        if (m_slot[4] != 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        empty = (occ == 0);
        case (m_state)
            ST_HALTED: if (!h) begin
                if (r) m_state = ST_RUN;
                else if (s) m_state = ST_STEP;
            end
            ST_RUN:   if (h) m_state = ST_DRAIN;
            ST_STEP:  if (!sq) m_state = ST_DRAIN;
            default:  if (empty) m_state = ST_HALTED;
        endcase
        for (int k = 1; k <= 4; k++) m_slot[k] = nxt[k];
    endtask

    task automatic cycle(input logic r, input logic h, input logic s, input logic sq, input logic rs);
        run_i = r;
        halt_i = h;
        step_i = s;
        stallreq_id_i = sq;
        rst = rs;
        @(negedge clk);
        if (retire_o === 1'b1) retire_seen++;
        model_cycle(r, h, s, sq, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        int base;
        for (int k = 1; k <= 4; k++) m_slot[k] = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

        idle(10);
        check("idle_stall", 32'(stall_o), 32'd1);
        check("idle_halted", 32'(halted_o), 32'd1);
        check("idle_inflight", 32'(inflight_o), 32'd0);
        check("idle_cnt", 32'(retire_cnt_o), 32'd0);

        base = retire_seen;
        cycle(0, 0, 1, 0, 0);
        check("step_state_t1", 32'(state_o), 32'd2);
        check("step_stall_t1", 32'(stall_o), 32'd0);
        idle(5);
        check("step_cnt_t6", 32'(retire_cnt_o), 32'd1);
        check("step_draining_t6", 32'(state_o), 32'd3);
        idle(1);
        check("step_halted_t7", 32'(halted_o), 32'd1);
        check("step_one_retire", 32'(retire_seen - base), 32'd1);

        cycle(1, 0, 0, 0, 0);
        idle(20);
        cycle(0, 1, 0, 0, 0);
        check("halt_pc_hold", 32'(stall_o[0]), 32'd1);
        idle(5);
        check("halt_t6", 32'(halted_o), 32'd1);
        check("halt_cnt_wrap", 32'(retire_cnt_o), 32'((1 + 21) % 16));

        cycle(1, 0, 0, 0, 0);
        idle(6);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        idle(4);
        cycle(0, 1, 0, 0, 0);
        idle(7);

        base = retire_seen;
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        idle(8);
        check("stall_step_one_retire", 32'(retire_seen - base), 32'd1);
        check("stall_step_halted", 32'(halted_o), 32'd1);

        cycle(1, 0, 0, 0, 0);
        idle(9);
        cycle(0, 1, 0, 0, 0);
        idle(1);
        check("mid_drain_inflight", 32'(inflight_o), 32'd3);
        check("mid_drain_state", 32'(state_o), 32'd3);
        cycle(0, 0, 0, 0, 1);
        check("post_rst_halted", 32'(halted_o), 32'd1);
        check("post_rst_inflight", 32'(inflight_o), 32'd0);
        check("post_rst_cnt", 32'(retire_cnt_o), 32'd0);

        cycle(0, 1, 1, 0, 0);
        check("halt_step_stay", 32'(state_o), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 16) == 0, ($urandom % 24) == 0, ($urandom % 12) == 0,
                  ($urandom % 4) == 0, ($urandom % 150) == 0);
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the 5-stage 16-bit CPU. Generates the per-stage stall vector consumed by the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB registers, and merges ID hazard stalls with debug run, halt and single-step control. Tracks which pipeline slots hold real instructions so it can drain the pipe on halt and count retired instructions for the observer.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `run_i`  in  1  single-cycle pulse: start free-running from HALTED.
- `halt_i`  in  1  single-cycle pulse: stop fetching and drain.
- `step_i`  in  1  single-cycle pulse: from HALTED, execute exactly one instruction.
- `stallreq_id_i`  in  1  ID hazard stall request; level.
- `stall_o`  out  5  stage hold vector; 1 = hold. Bit 0 = PC, bit 1 = IF_ID, bit 2 = ID_EX, bit 3 = EX_MEM, bit 4 = MEM_WB.
- `state_o`  out  2  current state encoding.
- `halted_o`  out  1  1 when state is HALTED.
- `inflight_o`  out  3  number of valid instructions in IF_ID..MEM_WB (0..4).
- `retire_o`  out  1  1 when MEM_WB holds a valid instruction this cycle.
- `retire_cnt_o`  out  `CNT_W`  retired-instruction count; wraps.

## Operation
States and encodings: HALTED = 0, RUN = 1, STEP = 2, DRAIN = 3.

Stall vector by state:
- HALTED: `5'b00001`.
- RUN and STEP: `{3'b0, s, s}`, where s = `stallreq_id_i`.
- DRAIN: `{3'b0, s, 1'b1}`.

Pipe convention: a held stage feeding a non-held stage inserts a bubble into that next stage.

Valid tracking uses `v[4:1]`, one bit each for IF_ID, ID_EX, EX_MEM and MEM_WB. Each cycle:
- `v[4]<=v[3]`, `v[3]<=v[2]`.
- `v[2]<= stall_o[1] ? 0 : v[1]`.
- `v[1]<= stall_o[1] ? v[1] : ~stall_o[0]`.

Derived outputs:
- `retire_o = v[4]`.
- `inflight_o = popcount(v)`.
- `retire_cnt_o` increments on each edge where `retire_o` is 1, and wraps from all-ones to 0.

Transitions:
- HALTED: `halt_i` → stay (halt wins over `run_i` and `step_i`). Else `run_i` → RUN. Else `step_i` → STEP. Else stay.
- RUN: `halt_i` → DRAIN. `run_i` and `step_i` are ignored.
- STEP: `stallreq_id_i` = 0 → DRAIN (the one fetch happens this cycle). Otherwise stay in STEP until the stall clears.
- DRAIN: when `v == 0` → HALTED. DRAIN is not abortable; `run_i`, `step_i` and `halt_i` are ignored.

Reset:
- `rst` = 1 → state HALTED, `v` = 0, counter = 0. This applies from any state, including mid-drain or mid-step.
- While `rst` = 1, `stall_o = 5'b00001`, `halted_o = 1`, `inflight_o = 0`, `retire_o = 0`, `retire_cnt_o = 0`, `state_o = 0`.

## Timing
- Registered: state, `v`, counter. `stall_o`, `halted_o`, `inflight_o`, `retire_o` and `state_o` are combinational from the registers (plus `stallreq_id_i`).
- Step with no hazard, `step_i` at cycle T:
  - STEP at T+1, with `stall_o` = 0.
  - `v[1]` set at T+2, while in DRAIN.
  - `retire_o` = 1 at T+5.
  - `retire_cnt_o` +1 visible at T+6.
  - `v` = 0 at T+6, HALTED at T+7.
- Halt from RUN with no hazard, `halt_i` at T:
  - The fetch at T still occurs.
  - DRAIN at T+1; last retire at T+4; HALTED at T+6.
- `stallreq_id_i` in DRAIN holds IF_ID and delays the exit by one cycle per stalled cycle.
- A pulse arriving in a state that ignores it is dropped; pulses are not queued.

## Structure
- Add to the shared defines:
  - `StallBus` = 4:0.
  - Stage index constants `STALL_PC`, `STALL_IFID`, `STALL_IDEX`, `STALL_EXMEM`, `STALL_MEMWB`.
  - State constants `CTRL_HALTED`, `CTRL_RUN`, `CTRL_STEP`, `CTRL_DRAIN`.
- One sub-module: `pipe_occupancy`. It takes `clk`, `rst` and `stall_o`, and produces `v`, `inflight_o` and `retire_o`. The FSM and counter remain in `pipe_ctrl`.

## Test plan
- Reset, then idle 10 cycles → `stall_o` = 00001, `halted_o` = 1, `inflight_o` = 0, `retire_cnt_o` = 0.
- `step_i` at T, no hazard → STEP at T+1, `stall_o` = 0 at T+1 only, `retire_o` = 1 only at T+5, count = 1 at T+6, HALTED at T+7.
- `run_i`, 20 cycles, `halt_i` at T → `stall_o[0]` = 1 from T+1, 4 more retires, HALTED at T+6, `retire_cnt_o` = total fetches.
- In RUN, `stallreq_id_i` high 2 cycles → `stall_o` = 00011 for those cycles, one bubble per cycle reaches MEM_WB 3 cycles later (`retire_o` = 0), `inflight_o` drops accordingly.
- `step_i` with `stallreq_id_i` = 1 for 3 cycles → stays in STEP 3 cycles with `stall_o` = 00011, then fetches once, exactly 1 retire.
- `rst` asserted mid-DRAIN with `inflight_o` = 3 → next cycle HALTED, `inflight_o` = 0, count = 0. Also: `halt_i` + `step_i` together in HALTED → no state change. Counter preset near wrap via 2^CNT_W retires (`CNT_W` = 4) → wraps to 0.
